fruit_spawn_scheduler: RTL



---
 rtl/fruit_pkg.sv | 32 +++
 rtl/fruit_spawn_scheduler_lfsr16.sv | 21 ++
 rtl/fruit_spawn_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit spawn scheduler: slot record, FSM
// state encoding and the small helpers used by the update datapath.
package fruit_pkg;

    typedef struct packed {
        logic              active;
        logic [9:0]        x;
        logic signed [10:0] y;
        logic signed [5:0]  vy;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SPAWN  = 2'd2
    } state_t;

    localparam int          SCORE_MAX    = 999;
    localparam int          MISS_MAX     = 3;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam int          SPAWN_X_BASE = 64;

    // Magnitude of a - b; operands are pre-extended to 12 bits so neither
    // the 10-bit unsigned X nor the 11-bit signed Y can overflow.
    function automatic logic [11:0] abs_diff(input logic signed [11:0] a,
                                             input logic signed [11:0] b);
        logic signed [11:0] d;
        d = a - b;
        return (d < 0) ? 12'(-d) : 12'(d);
    endfunction

endpackage

// File: rtl/fruit_spawn_scheduler_lfsr16.sv
// 16-bit Galois LFSR (right-shifting, taps in LFSR_MASK) supplying spawn
// X positions and launch speeds; advances every clock outside reset.
module lfsr16
    import fruit_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] value
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            value <= SEED;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/fruit_spawn_scheduler.sv
// Frame-rate fruit pool: per frame it walks every slot (hit, fall, miss),
// then makes one spawn attempt. Slot state and score feed the display path.
module fruit_spawn_scheduler
    import fruit_pkg::*;
#(
    parameter int          NUM_SLOTS    = 4,
    parameter int          SPAWN_PERIOD = 60,
    parameter int          Y_START      = 479,
    parameter int          GRAVITY      = 1,
    parameter int          HIT_R        = 16,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_tick,
    input  logic                    enable,
    input  logic                    slice_valid,
    input  logic [9:0]              slice_x,
    input  logic [9:0]              slice_y,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [10*NUM_SLOTS-1:0] slot_x,
    output logic [10*NUM_SLOTS-1:0] slot_y,
    output logic [9:0]              score,
    output logic [1:0]              misses,
    output logic                    game_over,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    slot_t              slots_q [NUM_SLOTS];
    logic [CNT_W-1:0]   spawn_cnt_q;
    logic               pend_q;
    logic [9:0]         sx_q, sy_q;
    logic [9:0]         score_q;
    logic [1:0]         misses_q;
    logic               game_over_q;
    logic [15:0]        lfsr;
    logic               unused_lfsr;

    slot_t              cur;
    logic [11:0]        dx, dy;
    logic signed [11:0] y_sum, y_new;
    logic signed [5:0]  vy_new;
    logic               hit, miss, last_idx;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .value (lfsr)
    );

    assign unused_lfsr = ^{lfsr[15:13], lfsr[9]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_tick && enable && !game_over_q) state_d = UPDATE;
            UPDATE:  if (last_idx) state_d = SPAWN;
            SPAWN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath for the slot selected by idx_q; hit uses the stored position.
    always_comb begin
        cur      = slots_q[idx_q];
        last_idx = (idx_q == IDX_W'(NUM_SLOTS - 1));
        dx       = abs_diff({2'b00, cur.x}, {2'b00, sx_q});
        dy       = abs_diff({cur.y[10], cur.y}, {2'b00, sy_q});
        hit      = cur.active && pend_q && (dx < 12'(HIT_R)) && (dy < 12'(HIT_R));
        y_sum    = {cur.y[10], cur.y} + {{6{cur.vy[5]}}, cur.vy};
        y_new    = (y_sum < 0) ? 12'sd0 : y_sum;
        vy_new   = cur.vy + 6'(GRAVITY);
        miss     = cur.active && !hit && (cur.vy > 0) && (y_new > $signed(12'(Y_START)));
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots_q[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // slice_valid is a fire-and-forget pulse with no ready: it is captured in
    // every state and the most recent pulse wins over both older data and the
    // end-of-frame clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
            spawn_cnt_q <= CNT_W'(SPAWN_PERIOD - 1);
            pend_q      <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            game_over_q <= (misses_q == 2'(MISS_MAX));
            if (slice_valid) begin
                pend_q <= 1'b1;
                sx_q   <= slice_x;
                sy_q   <= slice_y;
            end else if (state_q == UPDATE && last_idx) begin
                pend_q <= 1'b0;
            end
            case (state_q)
                IDLE: idx_q <= '0;
                UPDATE: begin
                    idx_q <= last_idx ? '0 : idx_q + 1'b1;
                    if (hit) begin
                        slots_q[idx_q].active <= 1'b0;
                        if (score_q != 10'(SCORE_MAX)) score_q <= score_q + 10'd1;
                    end else if (miss) begin
                        slots_q[idx_q].active <= 1'b0;
                        if (misses_q != 2'(MISS_MAX)) misses_q <= misses_q + 2'd1;
                    end else if (cur.active) begin
                        slots_q[idx_q].y  <= y_new[10:0];
                        slots_q[idx_q].vy <= vy_new;
                    end
                end
                SPAWN: begin
                    if (spawn_cnt_q == '0) begin
                        spawn_cnt_q <= CNT_W'(SPAWN_PERIOD - 1);
                        if (free_found) begin
                            slots_q[free_idx].active <= 1'b1;
                            slots_q[free_idx].x  <= 10'(SPAWN_X_BASE) + {1'b0, lfsr[8:0]};
                            slots_q[free_idx].y  <= 11'(Y_START);
                            slots_q[free_idx].vy <= -(6'd8 + {3'b000, lfsr[12:10]});
                        end
                    end else begin
                        spawn_cnt_q <= spawn_cnt_q - 1'b1;
                    end
                end
                default: idx_q <= '0;
            endcase
        end
    end

    always_comb begin
        slot_active = '0;
        slot_x      = '0;
        slot_y      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_active[i]    = slots_q[i].active;
            slot_x[10*i +: 10] = slots_q[i].x;
            slot_y[10*i +: 10] = slots_q[i].y[9:0];
        end
    end

    assign score     = score_q;
    assign misses    = misses_q;
    assign game_over = game_over_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
